ac97_cmd_sequencer: RTL

AC97_CMD_SEQUENCER -- requirements
Module: ac97_cmd_sequencer

---
 rtl/ac97_cmd_sequencer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/ac97_cmd_sequencer.sv
// AC97 codec command sequencer: writes a fixed init table after link-ready,
// then serves master-volume writes, holding each command for HOLD_FRAMES frames.
module ac97_cmd_sequencer #(
    parameter int unsigned HOLD_FRAMES = 32'd2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ac97_ready_sig,
    input  logic        frame_sync,
    input  logic        vol_req,
    input  logic [4:0]  vol_left,
    input  logic [4:0]  vol_right,
    input  logic        mute,
    output logic [7:0]  cmd_addr,
    output logic [15:0] cmd_data,
    output logic        latching_cmd,
    output logic        vol_ack,
    output logic        init_done,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_WAIT_READY = 3'd0,
        S_LOAD       = 3'd1,
        S_HOLD       = 3'd2,
        S_IDLE       = 3'd3,
        S_VOL_LOAD   = 3'd4,
        S_VOL_HOLD   = 3'd5
    } state_t;

    localparam logic [3:0] HOLD_LIMIT = HOLD_FRAMES[3:0];

    state_t      state_q, state_d;
    logic [1:0]  index_q, index_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  cmd_addr_q, cmd_addr_d;
    logic [15:0] cmd_data_q, cmd_data_d;
    logic        latching_q, latching_d;
    logic        vol_ack_q, vol_ack_d;
    logic        init_done_q, init_done_d;
    logic        busy_q, busy_d;
    logic        hold_done_s;

    function automatic logic [23:0] init_entry(input logic [1:0] idx);
        case (idx)
            2'd0:    return {8'h02, 16'h0000};
            2'd1:    return {8'h18, 16'h0808};
            2'd2:    return {8'h1A, 16'h0000};
            2'd3:    return {8'h1C, 16'h0000};
            default: return 24'h000000;
        endcase
    endfunction

    // The pulse that completes the hold is consumed by the transition, never carried over.
    assign hold_done_s = frame_sync && ((cnt_q + 4'd1) == HOLD_LIMIT);

    // State, index, hold counter and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_WAIT_READY;
            index_q     <= 2'd0;
            cnt_q       <= 4'd0;
            cmd_addr_q  <= 8'h00;
            cmd_data_q  <= 16'h0000;
            latching_q  <= 1'b0;
            vol_ack_q   <= 1'b0;
            init_done_q <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            cnt_q       <= cnt_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_data_q  <= cmd_data_d;
            latching_q  <= latching_d;
            vol_ack_q   <= vol_ack_d;
            init_done_q <= init_done_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state, table index and frame counting; ready loss overrides everything.
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        cnt_d   = cnt_q;
        if ((state_q != S_WAIT_READY) && !ac97_ready_sig) begin
            state_d = S_WAIT_READY;
            index_d = 2'd0;
            cnt_d   = 4'd0;
        end else begin
            case (state_q)
                S_WAIT_READY: begin
                    if (ac97_ready_sig) begin
                        state_d = S_LOAD;
                        index_d = 2'd0;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = S_WAIT_READY;
                    end
                end
                S_LOAD: begin
                    state_d = S_HOLD;
                    cnt_d   = 4'd0;
                end
                S_HOLD: begin
                    if (hold_done_s) begin
                        cnt_d = 4'd0;
                        if (index_q == 2'd3) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_LOAD;
                            index_d = index_q + 2'd1;
                        end
                    end else if (frame_sync) begin
                        cnt_d = cnt_q + 4'd1;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                S_IDLE: begin
                    if (vol_req) begin
                        state_d = S_VOL_LOAD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_VOL_LOAD: begin
                    state_d = S_VOL_HOLD;
                    cnt_d   = 4'd0;
                end
                S_VOL_HOLD: begin
                    if (hold_done_s) begin
                        cnt_d   = 4'd0;
                        state_d = S_IDLE;
                    end else if (frame_sync) begin
                        cnt_d = cnt_q + 4'd1;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                default: begin
                    state_d = S_WAIT_READY;
                    index_d = 2'd0;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    // Output values for the state being entered, so strobes line up with LOAD cycles.
    always_comb begin
        cmd_addr_d  = cmd_addr_q;
        cmd_data_d  = cmd_data_q;
        latching_d  = 1'b0;
        vol_ack_d   = 1'b0;
        init_done_d = init_done_q;
        busy_d      = (state_d != S_IDLE);
        case (state_d)
            S_LOAD: begin
                {cmd_addr_d, cmd_data_d} = init_entry(index_d);
                latching_d = 1'b1;
            end
            S_VOL_LOAD: begin
                cmd_addr_d = 8'h02;
                cmd_data_d = {mute, 2'b00, vol_left, 3'b000, vol_right};
                latching_d = 1'b1;
                vol_ack_d  = 1'b1;
            end
            S_WAIT_READY: init_done_d = 1'b0;
            S_IDLE:       init_done_d = 1'b1;
            default:      init_done_d = init_done_q;
        endcase
    end

    assign cmd_addr     = cmd_addr_q;
    assign cmd_data     = cmd_data_q;
    assign latching_cmd = latching_q;
    assign vol_ack      = vol_ack_q;
    assign init_done    = init_done_q;
    assign busy         = busy_q;

endmodule
